// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix output stage: word format, FSM encoding
// and the saturating adder used on the drain path.
package matrix_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Both operands share FRAC_WIDTH, so a plain add keeps the binary point.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      sat_add = s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/sat_add_relu.sv
// Bias add with saturation and optional ReLU; result captured in an output
// register when i_load is high.
module sat_add_relu
  import matrix_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load,
  input  logic                         i_relu,
  input  logic signed [DATA_WIDTH-1:0] i_c,
  input  logic signed [DATA_WIDTH-1:0] i_bias,
  output logic signed [DATA_WIDTH-1:0] o_data
);

  logic signed [DATA_WIDTH-1:0] w_sum;
  logic signed [DATA_WIDTH-1:0] w_act;

  always_comb begin
    w_sum = sat_add(i_c, i_bias);
    if (i_relu && w_sum[DATA_WIDTH-1]) begin
      w_act = {DATA_WIDTH{1'b0}};
    end else begin
      w_act = w_sum;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data <= {DATA_WIDTH{1'b0}};
    end else if (i_load) begin
      o_data <= w_act;
    end
  end

endmodule

// File: rtl/matrix_out_bias_act.sv
// Collects an out-of-order M x N result matrix, then drains it row-major with
// per-column bias, saturation and optional ReLU under valid/ready flow control.
module matrix_out_bias_act
  import matrix_pkg::*;
#(
  parameter  int M    = 4,
  parameter  int N    = 2,
  localparam int RW   = $clog2(M),
  localparam int CW   = $clog2(N),
  localparam int NE   = M * N,
  localparam int IW   = $clog2(NE),
  localparam int CNTW = $clog2(NE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         relu_en,
  input  logic signed [DATA_WIDTH-1:0] bias_data,
  input  logic [CW-1:0]                bias_col,
  input  logic                         bias_valid,
  input  logic signed [DATA_WIDTH-1:0] c_data,
  input  logic [RW-1:0]                c_row,
  input  logic [CW-1:0]                c_col,
  input  logic                         c_valid,
  input  logic                         c_done,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [RW-1:0]                out_row,
  output logic [CW-1:0]                out_col,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         done,
  output logic                         busy,
  output logic                         err
);

  state_t                       r_state;
  logic signed [DATA_WIDTH-1:0] r_buf [NE];
  logic [NE-1:0]                r_map;
  logic [CNTW-1:0]              r_count;
  logic signed [DATA_WIDTH-1:0] r_bias [N];
  logic [CNTW-1:0]              r_rd_ptr;
  logic [RW-1:0]                r_row;
  logic [CW-1:0]                r_col;
  logic                         r_relu, r_err, r_busy, r_done, r_valid, r_last;

  logic                         w_c_ok, w_bias_ok, w_c_new, w_hs, w_load;
  logic [IW-1:0]                w_c_idx, w_rd_idx;
  logic [CW-1:0]                w_rd_col;
  logic [CNTW-1:0]              w_count_nxt;
  logic signed [DATA_WIDTH-1:0] w_rd_c;

  always_comb begin
    w_c_ok      = (int'(c_row) < M) && (int'(c_col) < N);
    w_bias_ok   = int'(bias_col) < N;
    w_c_idx     = IW'(int'(c_row) * N + int'(c_col));
    w_c_new     = (r_state == S_COLLECT) && c_valid && w_c_ok && !r_map[w_c_idx];
    w_count_nxt = w_c_new ? r_count + 1'b1 : r_count;
    w_hs        = r_valid && out_ready;
    w_load      = (r_state == S_DRAIN) && !start && (!r_valid || w_hs) &&
                  (r_rd_ptr < CNTW'(NE));
    w_rd_idx    = r_rd_ptr[IW-1:0];
    w_rd_col    = CW'(int'(w_rd_idx) % N);
    // Cells never written this matrix read as zero, so they drain as bias only.
    w_rd_c      = r_map[w_rd_idx] ? r_buf[w_rd_idx] : {DATA_WIDTH{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (!rst && !start && (r_state == S_COLLECT) && c_valid && w_c_ok) begin
      r_buf[w_c_idx] <= c_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_map    <= {NE{1'b0}};
      r_count  <= {CNTW{1'b0}};
      r_rd_ptr <= {CNTW{1'b0}};
      r_row    <= {RW{1'b0}};
      r_col    <= {CW{1'b0}};
      r_relu   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      for (int i = 0; i < N; i++) r_bias[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (bias_valid && (r_state != S_DRAIN) && w_bias_ok) begin
        r_bias[bias_col] <= bias_data;
      end
      if (start) begin
        r_state  <= S_COLLECT;
        r_busy   <= 1'b1;
        r_map    <= {NE{1'b0}};
        r_count  <= {CNTW{1'b0}};
        r_rd_ptr <= {CNTW{1'b0}};
        r_err    <= 1'b0;
        r_relu   <= relu_en;
        r_valid  <= 1'b0;
        r_last   <= 1'b0;
      end else begin
        if (bias_valid && (r_state != S_DRAIN) && !w_bias_ok) r_err <= 1'b1;
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_COLLECT: begin
            if (c_valid) begin
              if (!w_c_ok || r_map[w_c_idx]) r_err <= 1'b1;
              if (w_c_new) r_map[w_c_idx] <= 1'b1;
            end
            r_count <= w_count_nxt;
            if ((w_count_nxt == CNTW'(NE)) || c_done) begin
              r_state <= S_DRAIN;
              if (w_count_nxt != CNTW'(NE)) r_err <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (c_valid) r_err <= 1'b1;
            if (w_hs && r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_load) begin
              r_valid  <= 1'b1;
              r_row    <= RW'(int'(r_rd_ptr) / N);
              r_col    <= w_rd_col;
              r_last   <= (r_rd_ptr == CNTW'(NE - 1));
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end else if (w_hs) begin
              r_valid <= 1'b0;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_add_relu u_sat_add_relu (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load),
    .i_relu (r_relu),
    .i_c    (w_rd_c),
    .i_bias (r_bias[w_rd_col]),
    .o_data (out_data)
  );

  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign done      = r_done;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_matrix_out_bias_act.sv
// Directed bench for matrix_out_bias_act (M=4, N=2, Q8.8) with an arithmetic
// reference model and a per-cycle output checker.
module tb_matrix_out_bias_act;

  logic        clk = 1'b0;
  logic        rst, start, relu_en, bias_valid, c_valid, c_done, out_ready;
  logic [15:0] bias_data, c_data;
  logic        bias_col, c_col;
  logic [1:0]  c_row;
  logic [15:0] out_data;
  logic [1:0]  out_row;
  logic        out_col, out_valid, out_last, done, busy, err;

  matrix_out_bias_act #(.M(4), .N(2)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .bias_data(bias_data), .bias_col(bias_col), .bias_valid(bias_valid),
    .c_data(c_data), .c_row(c_row), .c_col(c_col), .c_valid(c_valid), .c_done(c_done),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  row;
    logic        col;
    logic        last;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [15:0] m_c[4][2];
  bit                 m_w[4][2];
  logic signed [15:0] m_bias[2];
  bit                 m_relu;
  logic [15:0]        tc[8];
  int                 n_chk = 0, n_fail = 0, n_hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: real-valued sum of C and bias, clamped to the Q8.8 range, then ReLU.
  function automatic logic [15:0] exp_val(input int r, input int c);
    int s;
    s = (m_w[r][c] ? int'(m_c[r][c]) : 0) + int'(m_bias[c]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (m_relu && s < 0) s = 0;
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bias(input int col, input logic [15:0] v);
    bias_valid = 1'b1; bias_col = col[0]; bias_data = v; m_bias[col] = v;
    tick();
    bias_valid = 1'b0;
  endtask

  task automatic start_mat(input bit relu);
    start = 1'b1; relu_en = relu; m_relu = relu;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 2; c++) m_w[r][c] = 1'b0;
    tick();
    start = 1'b0; relu_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_c(input int r, input int c, input logic [15:0] v);
    c_valid = 1'b1; c_row = r[1:0]; c_col = c[0]; c_data = v;
    m_c[r][c] = v; m_w[r][c] = 1'b1;
    tick();
    c_valid = 1'b0;
  endtask

  task automatic arm();
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        e.data = exp_val(r, c); e.row = r[1:0]; e.col = c[0]; e.last = (r == 3 && c == 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input bit toggle, input bit exp_err);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 200) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      tick();
      cyc++;
      if (done) seen = 1'b1;
    end
    chk("done_pulse_seen", {31'd0, seen}, 32'd1);
    chk("all_elements_drained", exp_q.size(), 32'd0);
    chk("err_after_drain", {31'd0, err}, {31'd0, exp_err});
    out_ready = 1'b1;
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Output checker: every handshake must match the model in order; stalls must hold.
  bit          prev_stall = 1'b0;
  logic [15:0] sv_data;
  logic [1:0]  sv_row;
  logic        sv_col, sv_last;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (prev_stall) begin
        chk("stall_data", {16'd0, out_data}, {16'd0, sv_data});
        chk("stall_row", {30'd0, out_row}, {30'd0, sv_row});
        chk("stall_col", {31'd0, out_col}, {31'd0, sv_col});
        chk("stall_last", {31'd0, out_last}, {31'd0, sv_last});
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got row %0d col %0d data 0x%0h, required none",
                   out_row, out_col, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, e.data});
          chk("out_row", {30'd0, out_row}, {30'd0, e.row});
          chk("out_col", {31'd0, out_col}, {31'd0, e.col});
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
          n_hs++;
        end
      end
      prev_stall = !out_ready;
      sv_data = out_data; sv_row = out_row; sv_col = out_col; sv_last = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int base, cyc;
    tc = '{16'h0400, 16'h0500, 16'h0A00, 16'h0B00, 16'h1000, 16'h1100, 16'h0300, 16'h0200};
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; bias_valid = 1'b0; c_valid = 1'b0;
    c_done = 1'b0; out_ready = 1'b1; bias_data = 16'h0000; bias_col = 1'b0;
    c_data = 16'h0000; c_row = 2'd0; c_col = 1'b0; m_relu = 1'b0;
    m_bias[0] = 16'h0000; m_bias[1] = 16'h0000;
    tick(); tick();
    rst = 1'b0;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_data", {16'd0, out_data}, 32'd0);

    // 1: row-major writes, bias {0.5, -1.0}
    write_bias(0, 16'h0080);
    write_bias(1, 16'hFF00);
    start_mat(1'b0);
    chk("busy_collect", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) write_c(i / 2, i % 2, tc[i]);
    chk("model_pin_4p5", {16'd0, exp_val(0, 0)}, 32'h0480);
    chk("model_pin_1p0", {16'd0, exp_val(3, 1)}, 32'h0100);
    arm();
    wait_drain(1'b0, 1'b0);

    // 2: column-major writes, same row-major result
    start_mat(1'b0);
    for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) write_c(r, c, tc[r * 2 + c]);
    arm();
    wait_drain(1'b0, 1'b0);

    // 3a: ReLU clamps a negative sum; positive overflow saturates
    write_bias(0, 16'h0080);
    write_bias(1, 16'h0100);
    start_mat(1'b1);
    for (int i = 0; i < 8; i++) write_c(i / 2, i % 2, (i == 0) ? 16'hFE00 : (i == 1) ? 16'h7F00 : tc[i]);
    chk("model_pin_relu", {16'd0, exp_val(0, 0)}, 32'h0000);
    chk("model_pin_satmax", {16'd0, exp_val(0, 1)}, 32'h7FFF);
    arm();
    wait_drain(1'b0, 1'b0);

    // 3b: saturation both ways with ReLU off
    write_bias(0, 16'hFF00);
    start_mat(1'b0);
    for (int i = 0; i < 8; i++) write_c(i / 2, i % 2, (i == 1) ? 16'h7F00 : (i == 2) ? 16'h8000 : tc[i]);
    chk("model_pin_satmax2", {16'd0, exp_val(0, 1)}, 32'h7FFF);
    chk("model_pin_satmin", {16'd0, exp_val(1, 0)}, 32'h8000);
    arm();
    wait_drain(1'b0, 1'b0);

    // 4: out_ready toggling every cycle
    write_bias(0, 16'h0080);
    write_bias(1, 16'hFF00);
    start_mat(1'b0);
    for (int i = 0; i < 8; i++) write_c(i / 2, i % 2, tc[i]);
    arm();
    wait_drain(1'b1, 1'b0);

    // 5a: duplicate write to (1,1), last value wins
    start_mat(1'b0);
    for (int i = 0; i < 4; i++) write_c(i / 2, i % 2, tc[i]);
    write_c(1, 1, 16'h0300);
    write_c(1, 1, 16'h0700);
    chk("err_on_duplicate", {31'd0, err}, 32'd1);
    for (int i = 4; i < 8; i++) write_c(i / 2, i % 2, tc[i]);
    chk("model_pin_dup", {16'd0, exp_val(1, 1)}, 32'h0600);
    arm();
    wait_drain(1'b0, 1'b1);

    // 5b: early c_done after 6 writes
    start_mat(1'b0);
    chk("err_cleared_by_start", {31'd0, err}, 32'd0);
    for (int i = 0; i < 6; i++) write_c(i / 2, i % 2, tc[i]);
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    chk("model_pin_missing0", {16'd0, exp_val(3, 0)}, 32'h0080);
    chk("model_pin_missing1", {16'd0, exp_val(3, 1)}, 32'hFF00);
    arm();
    wait_drain(1'b0, 1'b1);

    // 6: restart after 3 handshakes of a drain, then reset mid-collect
    start_mat(1'b0);
    for (int i = 0; i < 8; i++) write_c(i / 2, i % 2, tc[i]);
    arm();
    base = n_hs; cyc = 0; out_ready = 1'b1;
    while (n_hs < base + 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("three_handshakes", n_hs - base, 32'd3);
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    exp_q.delete();
    chk("restart_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_err", {31'd0, err}, 32'd0);
    out_ready = 1'b1;
    write_c(0, 0, tc[0]);
    write_c(0, 1, tc[1]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_row_col", {29'd0, out_row, out_col}, 32'd0);
    chk("rst_valid_last", {30'd0, out_valid, out_last}, 32'd0);
    chk("rst_done_busy_err", {29'd0, done, busy, err}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("rst_quiet", {30'd0, out_valid, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
